// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_DATA = 2'd1,
    ST_RMW  = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Access size; the unused encodings (3, 6, 7) fall back to a full word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      F3_LW:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  // Only LB and LH sign-extend; everything else is zero-extended.
  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store data into a word.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  lsu_size_t   w_size;
  logic        w_sext;
  logic [4:0]  w_shamt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  assign w_size  = f3_size(i_funct3);
  assign w_sext  = f3_signed(i_funct3);
  assign w_shamt = {i_offset, 3'b000};
  assign w_byte  = i_rdata[w_shamt +: 8];
  assign w_half  = i_rdata[{i_offset[1], 4'b0000} +: 16];

  // Load path: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    o_load_data = i_rdata;
    case (w_size)
      SZ_B:    o_load_data = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_H:    o_load_data = {{16{w_sext & w_half[15]}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Store path: replicate the store data across lanes, then mask in only the addressed lane.
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_lane = i_wdata;
    case (w_size)
      SZ_B: begin
        w_mask = 32'h0000_00FF << w_shamt;
        w_lane = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_mask = 32'h0000_FFFF << w_shamt;
        w_lane = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
    o_store_word = (i_rdata & ~w_mask) | (w_lane & w_mask);
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage LSU: maps RV32 loads/stores onto a word-only dmem with a 1-cycle registered read.
// Latency: SW writes in the accept cycle; loads pulse o_wb_valid 2 cycles after accept; SB/SH write 1 cycle after accept.
// Backpressure: o_ready is high only in IDLE; it drops for one cycle after a good load or sub-word store.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_load,
  input  logic                  i_store,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [4:0]            i_rd,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_wb_valid,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic [4:0]            o_wb_rd,
  output logic                  o_exc,
  output logic                  o_exc_cause,
  output logic [31:0]           o_exc_addr
);

  lsu_state_t            r_state, w_next_state;
  lsu_size_t             w_size;
  logic                  w_idle, w_accept, w_mis, w_oor, w_fault, w_take;
  logic                  w_ready, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [31:0]           w_load_data, w_merged;

  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [1:0]            r_offset;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [4:0]            r_rd;
  logic                  r_wb_valid, r_exc, r_exc_cause;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [4:0]            r_wb_rd;
  logic [31:0]           r_exc_addr;

  assign w_idle   = (r_state == IDLE);
  assign w_size   = f3_size(i_funct3);
  assign w_accept = i_valid & w_idle & (i_load | i_store);
  // Misalignment wins over range when both apply.
  assign w_mis    = ((w_size == SZ_H) & i_addr[0]) | ((w_size == SZ_W) & (|i_addr[1:0]));
  assign w_oor    = |i_addr[31:ADDR_WIDTH+2];
  assign w_fault  = w_mis | w_oor;
  assign w_take   = w_accept & ~w_fault;

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_offset),
    .i_rdata      (i_dmem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_merged)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next state: loads and sub-word stores take one extra cycle; SW and faults stay in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_take && i_load)                            w_next_state = LD_DATA;
        else if (w_take && i_store && (w_size != SZ_W)) w_next_state = ST_RMW;
      end
      LD_DATA: w_next_state = IDLE;
      ST_RMW:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // dmem drive: IDLE follows the EX inputs directly, the second cycle uses the latched address.
  always_comb begin
    w_ready = 1'b0;
    w_we    = 1'b0;
    w_addr  = i_addr[ADDR_WIDTH+1:2];
    w_wdata = i_wdata;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_we    = w_take & i_store & ~i_load & (w_size == SZ_W);
      end
      LD_DATA: w_addr = r_waddr;
      ST_RMW: begin
        w_addr  = r_waddr;
        w_wdata = w_merged;
        w_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // dmem has no reset of its own, so writes are gated while reset is held.
  assign o_ready      = w_ready;
  assign o_dmem_we    = w_we & i_rst_n;
  assign o_dmem_addr  = w_addr;
  assign o_dmem_wdata = w_wdata;

  // Capture the op on a fault-free accept for use in the second cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_waddr  <= '0;
      r_offset <= 2'b00;
      r_funct3 <= 3'b000;
      r_wdata  <= '0;
      r_rd     <= 5'd0;
    end else if (w_take) begin
      r_waddr  <= i_addr[ADDR_WIDTH+1:2];
      r_offset <= i_addr[1:0];
      r_funct3 <= i_funct3;
      r_wdata  <= i_wdata;
      r_rd     <= i_rd;
    end
  end

  // Writeback and fault reporting; pulses last one cycle, payloads hold until the next event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_rd     <= 5'd0;
      r_exc       <= 1'b0;
      r_exc_cause <= 1'b0;
      r_exc_addr  <= 32'd0;
    end else begin
      r_wb_valid <= (r_state == LD_DATA);
      if (r_state == LD_DATA) begin
        r_wb_data <= w_load_data;
        r_wb_rd   <= r_rd;
      end
      r_exc <= w_accept & w_fault;
      if (w_accept && w_fault) begin
        r_exc_cause <= ~w_mis;
        r_exc_addr  <= i_addr;
      end
    end
  end

  assign o_wb_valid  = r_wb_valid;
  assign o_wb_data   = r_wb_data;
  assign o_wb_rd     = r_wb_rd;
  assign o_exc       = r_exc;
  assign o_exc_cause = r_exc_cause;
  assign o_exc_addr  = r_exc_addr;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, hand-timed corner cases, randomized stream vs a byte-level model.
// Latency: n/a (testbench).
// Backpressure: stimulus holds each op until o_ready, matching an EX stage that stalls.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int AW = 9;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_load, i_store;
  logic [2:0]    i_funct3;
  logic [31:0]   i_addr, i_wdata;
  logic [4:0]    i_rd;
  logic          o_ready, o_dmem_we;
  logic [AW-1:0] o_dmem_addr;
  logic [31:0]   o_dmem_wdata, dmem_rdata;
  logic          o_wb_valid;
  logic [31:0]   o_wb_data;
  logic [4:0]    o_wb_rd;
  logic          o_exc, o_exc_cause;
  logic [31:0]   o_exc_addr;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_load(i_load), .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rd(i_rd), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(dmem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
    .o_exc_addr(o_exc_addr)
  );

  // Word memory with 1-cycle registered read, preloaded from init_words on the first edge.
  logic [31:0] dmem [0:NW-1];
  logic [31:0] init_words [0:NW-1];
  logic        init_loaded = 1'b0;
  always @(posedge clk) begin
    if (!init_loaded) begin
      for (int w = 0; w < NW; w++) dmem[w] <= init_words[w];
      init_loaded <= 1'b1;
    end else if (o_dmem_we) begin
      dmem[o_dmem_addr] <= o_dmem_wdata;
    end
    dmem_rdata <= dmem[o_dmem_addr];
  end

  // Observed events.
  logic [36:0] wb_obs[$], wb_exp[$];
  logic [32:0] exc_obs[$], exc_exp[$];
  int          wr_cnt = 0;
  always @(negedge clk) begin
    if (o_wb_valid === 1'b1) wb_obs.push_back({o_wb_rd, o_wb_data});
    if (o_exc === 1'b1)      exc_obs.push_back({o_exc_cause, o_exc_addr});
    if (o_dmem_we === 1'b1)  wr_cnt <= wr_cnt + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a flat byte memory with RV32 load/store semantics.
  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    op_t         op;
    logic        exp_exc;
    logic        exp_cause;
    logic [31:0] exp_val;
  } vec_t;

  logic [7:0] ref_b [0:4*NW-1];
  int         busy = 0;
  int         exp_wr = 0;

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic op_t mk(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
    op_t o;
    o.ld = ld; o.st = ~ld; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rd = rd;
    return o;
  endfunction

  function automatic logic faulty(input op_t op);
    return ((op.addr % 32'(nbytes(op.f3))) != 0) || (op.addr >= 32'(4 * NW));
  endfunction

  task automatic model_accept(input op_t op);
    int          n;
    logic [31:0] v;
    n = nbytes(op.f3);
    if ((op.addr % 32'(n)) != 0) begin
      exc_exp.push_back({1'b0, op.addr});
    end else if (op.addr >= 32'(4 * NW)) begin
      exc_exp.push_back({1'b1, op.addr});
    end else if (op.ld) begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_b[int'(op.addr) + k]) << (8 * k));
      if ((op.f3 == 3'd0 || op.f3 == 3'd1) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      wb_exp.push_back({op.rd, v});
      busy = 1;
    end else begin
      for (int k = 0; k < n; k++) ref_b[int'(op.addr) + k] = op.wdata[8*k +: 8];
      exp_wr++;
      busy = (n == 4) ? 0 : 1;
    end
  endtask

  // Entered and left at posedge+1; leaves the op driven so a following send keeps i_valid high.
  task automatic send(input op_t op);
    int   n;
    logic sw_ok;
    n = 0;
    i_valid = 1'b1; i_load = op.ld; i_store = op.st; i_funct3 = op.f3;
    i_addr = op.addr; i_wdata = op.wdata; i_rd = op.rd;
    @(negedge clk);
    chk("ready", o_ready, busy == 0);
    while (o_ready !== 1'b1 && n < 8) begin
      if (busy > 0) busy--;
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_wait", o_ready, busy == 0);
      n++;
    end
    if (o_ready !== 1'b1) begin
      chk("accept_timeout", 1'b0, 1'b1);
    end else begin
      sw_ok = op.st && nbytes(op.f3) == 4 && !faulty(op);
      chk("acc_we", o_dmem_we, sw_ok);
      chk("acc_dmem_addr", o_dmem_addr, op.addr[AW+1:2]);
      if (sw_ok) chk("acc_sw_wdata", o_dmem_wdata, op.wdata);
      model_accept(op);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    i_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("idle_ready", o_ready, busy == 0);
      if (busy > 0) busy--;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_check(input string tag);
    int n;
    idle(4);
    chk({tag, "_wb_count"}, wb_obs.size(), wb_exp.size());
    n = (wb_obs.size() < wb_exp.size()) ? wb_obs.size() : wb_exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_wb%0d", tag, i), wb_obs[i], wb_exp[i]);
    chk({tag, "_exc_count"}, exc_obs.size(), exc_exp.size());
    n = (exc_obs.size() < exc_exp.size()) ? exc_obs.size() : exc_exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_exc%0d", tag, i), exc_obs[i], exc_exp[i]);
    chk({tag, "_writes"}, wr_cnt, exp_wr);
    for (int w = 0; w < NW; w++)
      chk($sformatf("%s_mem%0d", tag, w), dmem[w],
          {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
    wb_obs.delete(); wb_exp.delete(); exc_obs.delete(); exc_exp.delete();
  endtask

  vec_t tbl[$];
  op_t  rop;

  task automatic add(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exc, input logic cause,
                     input logic [31:0] val);
    vec_t v;
    v.op = mk(ld, f3, addr, wdata, 5'(tbl.size() + 1));
    v.exp_exc = exc; v.exp_cause = cause; v.exp_val = val;
    tbl.push_back(v);
  endtask

  initial begin
    int          wb0, exc0, wr0, r;
    logic [31:0] w, old;

    for (int i = 0; i < NW; i++) begin
      w = $urandom;
      init_words[i] = w;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
    end

    // Directed vectors: {ld, funct3, addr, wdata, fault?, cause, load result or stored word}.
    add(0, F3_LW,  32'h10,  32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    add(1, F3_LW,  32'h10,  32'h0,         0, 0, 32'hDEAD_BEEF);
    add(0, F3_LW,  32'h10,  32'h1122_3344, 0, 0, 32'h1122_3344);
    add(0, F3_LB,  32'h13,  32'h0000_00AA, 0, 0, 32'hAA22_3344);
    add(1, F3_LB,  32'h13,  32'h0,         0, 0, 32'hFFFF_FFAA);
    add(1, F3_LBU, 32'h13,  32'h0,         0, 0, 32'h0000_00AA);
    add(1, F3_LH,  32'h12,  32'h0,         0, 0, 32'hFFFF_AA22);
    add(1, F3_LHU, 32'h12,  32'h0,         0, 0, 32'h0000_AA22);
    add(1, F3_LB,  32'h10,  32'h0,         0, 0, 32'h0000_0044);
    add(0, F3_LH,  32'h12,  32'hCAFE_5678, 0, 0, 32'h5678_3344);
    add(1, F3_LH,  32'h12,  32'h0,         0, 0, 32'h0000_5678);
    add(0, F3_LB,  32'h11,  32'h1234_5680, 0, 0, 32'h5678_8044);
    add(1, F3_LB,  32'h11,  32'h0,         0, 0, 32'hFFFF_FF80);
    add(1, 3'd3,   32'h10,  32'h0,         0, 0, 32'h5678_8044);
    add(1, 3'd6,   32'h10,  32'h0,         0, 0, 32'h5678_8044);
    add(0, F3_LW,  32'h7FC, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);
    add(0, F3_LB,  32'h7FF, 32'h0000_0055, 0, 0, 32'h55AD_F00D);
    add(1, F3_LW,  32'h7FC, 32'h0,         0, 0, 32'h55AD_F00D);
    add(1, F3_LW,  32'h12,  32'h0,         1, 0, 32'h0);
    add(0, F3_LW,  32'h800, 32'h1234_5678, 1, 1, 32'h0);
    add(1, F3_LH,  32'h11,  32'h0,         1, 0, 32'h0);
    add(1, F3_LB,  32'h800, 32'h0,         1, 1, 32'h0);
    add(1, F3_LW,  32'h802, 32'h0,         1, 0, 32'h0);
    add(0, F3_LB,  32'h1000, 32'h77,       1, 1, 32'h0);

    // Reset with an SW presented: outputs at reset values and no write may leak out.
    rst_n = 1'b1;
    i_valid = 1'b1; i_load = 1'b0; i_store = 1'b1; i_funct3 = F3_LW;
    i_addr = 32'h10; i_wdata = 32'h0; i_rd = 5'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_we", o_dmem_we, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_wb_valid", o_wb_valid, 1'b0);
    chk("rst_wb_data", o_wb_data, 32'h0);
    chk("rst_wb_rd", o_wb_rd, 5'd0);
    chk("rst_exc", o_exc, 1'b0);
    chk("rst_exc_cause", o_exc_cause, 1'b0);
    chk("rst_exc_addr", o_exc_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 i_valid = 1'b0; rst_n = 1'b1;
    idle(1);
    chk("rst_no_write", wr_cnt, 0);

    // Directed table, one op at a time.
    foreach (tbl[i]) begin
      wb0 = wb_obs.size(); exc0 = exc_obs.size(); wr0 = wr_cnt;
      send(tbl[i].op);
      idle(3);
      if (tbl[i].exp_exc) begin
        chk($sformatf("t%0d_exc_pulses", i), exc_obs.size() - exc0, 1);
        if (exc_obs.size() > exc0)
          chk($sformatf("t%0d_exc", i), exc_obs[$], {tbl[i].exp_cause, tbl[i].op.addr});
        chk($sformatf("t%0d_no_wb", i), wb_obs.size() - wb0, 0);
        chk($sformatf("t%0d_no_write", i), wr_cnt - wr0, 0);
      end else if (tbl[i].op.ld) begin
        chk($sformatf("t%0d_wb_pulses", i), wb_obs.size() - wb0, 1);
        if (wb_obs.size() > wb0)
          chk($sformatf("t%0d_wb", i), wb_obs[$], {tbl[i].op.rd, tbl[i].exp_val});
      end else begin
        chk($sformatf("t%0d_word", i), dmem[tbl[i].op.addr[AW+1:2]], tbl[i].exp_val);
      end
    end
    drain_check("table");

    // Load latency: o_wb_valid rises exactly two cycles after the accepting edge.
    send(mk(0, F3_LW, 32'h10, 32'hDEAD_BEEF, 5'd0));
    send(mk(1, F3_LW, 32'h10, 32'h0, 5'd7));
    i_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_wb_valid", o_wb_valid, 1'b0);
    chk("lat_c1_ready", o_ready, 1'b0);
    busy = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c2_wb_valid", o_wb_valid, 1'b1);
    chk("lat_c2_wb_data", o_wb_data, 32'hDEAD_BEEF);
    chk("lat_c2_wb_rd", o_wb_rd, 5'd7);
    @(posedge clk); #1;
    drain_check("lat");

    // Reset asserted while an SH sits in its merge cycle: nothing may be written.
    wr0 = wr_cnt; old = dmem[1];
    i_valid = 1'b1; i_load = 1'b0; i_store = 1'b1; i_funct3 = F3_LH;
    i_addr = 32'h6; i_wdata = 32'h0000_BEEF; i_rd = 5'd0;
    @(negedge clk);
    chk("rmw_rst_accept_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rmw_rst_busy", o_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmw_rst_we", o_dmem_we, 1'b0);
    chk("rmw_rst_ready", o_ready, 1'b1);
    chk("rmw_rst_wb_valid", o_wb_valid, 1'b0);
    chk("rmw_rst_wb_data", o_wb_data, 32'h0);
    chk("rmw_rst_wb_rd", o_wb_rd, 5'd0);
    chk("rmw_rst_exc", o_exc, 1'b0);
    chk("rmw_rst_exc_cause", o_exc_cause, 1'b0);
    chk("rmw_rst_exc_addr", o_exc_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_rst_ready_after", o_ready, 1'b1);
    chk("rmw_rst_word", dmem[1], old);
    chk("rmw_rst_writes", wr_cnt - wr0, 0);
    @(posedge clk); #1;
    drain_check("rmw_rst");

    // Back-to-back stream with i_valid held high.
    send(mk(0, F3_LW, 32'h20, 32'hA1B2_C3D4, 5'd0));
    send(mk(0, F3_LW, 32'h24, 32'h5566_7788, 5'd0));
    send(mk(1, F3_LW, 32'h20, 32'h0, 5'd3));
    send(mk(0, F3_LB, 32'h21, 32'h0000_00EE, 5'd0));
    send(mk(1, F3_LW, 32'h20, 32'h0, 5'd4));
    drain_check("stream");

    // Randomized traffic, mostly in a small window to create read-after-write hazards.
    for (int i = 0; i < 400; i++) begin
      rop.ld = 1'($urandom_range(0, 1));
      rop.st = ~rop.ld;
      rop.f3 = rop.ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 15);
      if (r == 0)      rop.addr = $urandom;
      else if (r == 1) rop.addr = 32'h7F0 + 32'($urandom_range(0, 15));
      else             rop.addr = 32'($urandom_range(0, 127));
      rop.wdata = $urandom;
      rop.rd = 5'($urandom_range(0, 31));
      send(rop);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain_check("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
